// File: rtl/apb4_reg_completer.sv
// apb4_reg_completer
// APB4 completer front-end for a bank of 32-bit configuration registers.
// It decodes one APB4 transfer at a time into a single-cycle one-hot write
// strobe with a shared write-data bus. It also returns the addressed
// register's read data.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rstn       asynchronous active-low reset
//   psel       APB4 select
//   penable    APB4 enable (access phase)
//   pwrite     1 = write, 0 = read
//   paddr      byte address
//   pwdata     write data
//   pstrb      write byte strobes (only full-word writes are accepted)
//   prdata     read data, registered, non-zero only in the completion cycle
//   pready     transfer complete, registered, one cycle wide
//   pslverr    transfer error, registered, valid with pready
//   reg_write  one-hot write strobe, one bit per register
//   reg_wdata  write data to all registers, holds between writes
//   reg_rdata  concatenated register read data, register i at [32*i+31:32*i]
module apb4_reg_completer #(
  parameter logic [31:0] BASE_ADDR   = 32'hC0F16000,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [31:0]              paddr,
  input  logic [31:0]              pwdata,
  input  logic [3:0]               pstrb,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_REGS-1:0]      reg_write,
  output logic [31:0]              reg_wdata,
  input  logic [NUM_REGS*32-1:0]   reg_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;

  // Transfer attributes captured in the setup phase.
  logic                  wr_q;
  logic                  err_q;
  logic [31:0]           wdata_q;
  logic [9:0]            idx_q;

  logic                  setup;
  logic                  capture;
  logic                  req_err;
  logic [31:0]           rd_sel;
  logic [NUM_REGS-1:0]   idx_onehot;

  logic [31:0]           prdata_nxt;
  logic                  pready_nxt;
  logic                  pslverr_nxt;
  logic [NUM_REGS-1:0]   reg_write_nxt;
  logic [31:0]           reg_wdata_nxt;

  assign setup = psel && !penable;

  // The error decision is taken once, on the setup-phase address and strobes.
  // That way the later phases only need the one latched flag.
  assign req_err = (paddr[31:12] != BASE_ADDR[31:12])
                || (paddr[1:0] != 2'b00)
                || (int'({22'd0, paddr[11:2]}) >= NUM_REGS)
                || (pwrite && (pstrb != 4'hF));

  // Read mux and write decode. An out-of-range index matches no entry. Such
  // a transfer is always flagged as an error, so it never uses either result.
  always_comb begin
    rd_sel     = '0;
    idx_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_q == 10'(i)) begin
        rd_sel        = reg_rdata[32*i +: 32];
        idx_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    capture       = 1'b0;
    pready_nxt    = 1'b0;
    pslverr_nxt   = 1'b0;
    prdata_nxt    = '0;
    reg_write_nxt = '0;
    reg_wdata_nxt = reg_wdata;
    unique case (state)
      IDLE: begin
        if (setup) begin
          capture   = 1'b1;
          cnt_nxt   = 4'(WAIT_STATES);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          // Requester abandoned the transfer: no strobe, no pready.
          state_nxt = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt   = DONE;
          pready_nxt  = 1'b1;
          pslverr_nxt = err_q;
          if (!err_q && !wr_q) begin
            prdata_nxt = rd_sel;
          end
          if (!err_q && wr_q) begin
            reg_write_nxt = idx_onehot;
            reg_wdata_nxt = wdata_q;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- control and registered outputs ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
      reg_write <= '0;
      reg_wdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pready    <= pready_nxt;
      pslverr   <= pslverr_nxt;
      prdata    <= prdata_nxt;
      reg_write <= reg_write_nxt;
      reg_wdata <= reg_wdata_nxt;
    end
  end

  // ---- setup-phase capture ----
  // These registers are only consulted after a capture, so they need no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      wr_q    <= pwrite;
      err_q   <= req_err;
      wdata_q <= pwdata;
      idx_q   <= paddr[11:2];
    end
  end

endmodule
